// File: rtl/digit_timer_renderer.sv
// Two-digit BCD countdown timer with a two-stage sprite renderer.
// Decrements once per FRAMES_PER_SEC frame ticks; maps DrawX/DrawY to digit sprite texels.
module digit_timer_renderer #(
    parameter int         START_SECONDS  = 90,
    parameter int         FRAMES_PER_SEC = 60,
    parameter logic [9:0] X0             = 10'd288,
    parameter logic [9:0] Y0             = 10'd8,
    parameter logic [9:0] KEY_COLOR      = 10'd391
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] sprite_pixel,
    output logic [3:0] sprite_digit,
    output logic [4:0] sprite_row,
    output logic [4:0] sprite_col,
    output logic       pixel_on,
    output logic [9:0] pixel_color,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       time_up
);

    localparam logic [3:0] TENS0 = 4'(START_SECONDS / 10);
    localparam logic [3:0] ONES0 = 4'(START_SECONDS % 10);
    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_SEC - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

    state_t        state;
    logic [FW-1:0] fcnt;
    logic [3:0]    tens_nx;
    logic [3:0]    ones_nx;
    logic          zero_nx;

    // Saturating BCD decrement: 00 stays 00.
    always_comb begin
        tens_nx = tens;
        ones_nx = ones;
        if (ones != 4'd0) begin
            ones_nx = ones - 4'd1;
        end else if (tens != 4'd0) begin
            ones_nx = 4'd9;
            tens_nx = tens - 4'd1;
        end
    end

    assign zero_nx = (tens_nx == 4'd0) && (ones_nx == 4'd0);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= IDLE;
            tens    <= TENS0;
            ones    <= ONES0;
            fcnt    <= '0;
            time_up <= 1'b0;
        end else begin
            time_up <= (state == EXPIRED);
            if (start) begin
                state <= RUN;
                tens  <= TENS0;
                ones  <= ONES0;
                fcnt  <= '0;
            end else if (pause) begin
                case (state)
                    RUN:     state <= PAUSED;
                    PAUSED:  state <= RUN;
                    default: state <= state;
                endcase
            end else if (frame_tick && state == RUN) begin
                if (fcnt == FLAST) begin
                    fcnt <= '0;
                    tens <= tens_nx;
                    ones <= ones_nx;
                    if (zero_nx) begin
                        state <= EXPIRED;
                    end
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_y;
    logic       in_t;
    logic       in_o;
    logic       hit;

    // Offsets wrap when left/above the origin, so the >= checks reject those.
    assign dx   = DrawX - X0;
    assign dy   = DrawY - Y0;
    assign in_y = (DrawY >= Y0) && (dy < 10'd24);
    assign in_t = (DrawX >= X0) && (dx < 10'd32);
    assign in_o = (DrawX >= X0) && (dx >= 10'd32) && (dx < 10'd64);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            hit          <= 1'b0;
            sprite_digit <= 4'd0;
            sprite_row   <= 5'd0;
            sprite_col   <= 5'd0;
            pixel_on     <= 1'b0;
            pixel_color  <= 10'd0;
        end else begin
            if (in_y && (in_t || in_o)) begin
                hit          <= 1'b1;
                sprite_digit <= in_t ? tens : ones;
                sprite_row   <= dy[4:0];
                sprite_col   <= dx[4:0];
            end else begin
                hit          <= 1'b0;
                sprite_digit <= 4'd0;
                sprite_row   <= 5'd0;
                sprite_col   <= 5'd0;
            end
            if (hit && (sprite_pixel != KEY_COLOR)) begin
                pixel_on    <= 1'b1;
                pixel_color <= sprite_pixel;
            end else begin
                pixel_on    <= 1'b0;
                pixel_color <= 10'd0;
            end
        end
    end

endmodule

// File: tb/tb_digit_timer_renderer.sv
// Directed bench for digit_timer_renderer: countdown, pause, expiry,
// region decode and pixel keying, using a 90 s and a 10 s instance.
module tb_digit_timer_renderer;

    localparam logic [9:0] X0 = 10'd288;
    localparam logic [9:0] Y0 = 10'd8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] sprite_pixel = 10'd0;

    logic [3:0] sprite_digit;
    logic [4:0] sprite_row;
    logic [4:0] sprite_col;
    logic       pixel_on;
    logic [9:0] pixel_color;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       time_up;

    logic [3:0] sd10;
    logic [4:0] sr10;
    logic [4:0] sc10;
    logic       po10;
    logic [9:0] pc10;
    logic [3:0] tens10;
    logic [3:0] ones10;
    logic       tu10;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    digit_timer_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .start(start), .pause(pause), .DrawX(DrawX), .DrawY(DrawY),
        .sprite_pixel(sprite_pixel), .sprite_digit(sprite_digit),
        .sprite_row(sprite_row), .sprite_col(sprite_col),
        .pixel_on(pixel_on), .pixel_color(pixel_color),
        .tens(tens), .ones(ones), .time_up(time_up)
    );

    digit_timer_renderer #(.START_SECONDS(10)) dut10 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .start(start), .pause(pause), .DrawX(DrawX), .DrawY(DrawY),
        .sprite_pixel(sprite_pixel), .sprite_digit(sd10),
        .sprite_row(sr10), .sprite_col(sc10),
        .pixel_on(po10), .pixel_color(pc10),
        .tens(tens10), .ones(ones10), .time_up(tu10)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        cyc(1);
        pause = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_count", {tens, ones}, 8'h90);
        chk("rst_count10", {tens10, ones10}, 8'h10);
        chk("rst_time_up", time_up, 1'b0);
        chk("rst_pixel_on", pixel_on, 1'b0);
        chk("rst_color", pixel_color, 10'd0);
        chk("rst_addr", {sprite_digit, sprite_row, sprite_col}, 14'd0);
        Reset_n = 1'b1;
        cyc(1);

        tick(60);
        chk("idle_frozen", {tens, ones}, 8'h90);

        pulse_start();
        tick(60);
        chk("run_89", {tens, ones}, 8'h89);
        chk("ten_to_09", {tens10, ones10}, 8'h09);
        tick(480);
        chk("ten_at_01", {tens10, ones10}, 8'h01);
        tick(59);
        chk("ten_hold_01", {tens10, ones10}, 8'h01);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("ten_at_00", {tens10, ones10}, 8'h00);
        chk("ten_tu_lag", tu10, 1'b0);
        cyc(1);
        chk("ten_tu_high", tu10, 1'b1);
        tick(60);
        chk("ten_no_underflow", {tens10, ones10}, 8'h00);
        chk("ten_tu_stays", tu10, 1'b1);
        chk("run_79", {tens, ones}, 8'h79);

        pulse_start();
        chk("restart_90", {tens, ones}, 8'h90);
        chk("restart_tu_drop", tu10, 1'b1);
        cyc(1);
        chk("restart_tu_low", tu10, 1'b0);
        tick(2580);
        chk("run_47", {tens, ones}, 8'h47);

        sprite_pixel = 10'd428;
        DrawX = X0 + 10'd33;
        DrawY = Y0 + 10'd5;
        cyc(1);
        chk("ones_addr", {sprite_digit, sprite_row, sprite_col},
            {4'd7, 5'd5, 5'd1});
        cyc(1);
        chk("ones_on", pixel_on, 1'b1);
        chk("ones_color", pixel_color, 10'd428);
        sprite_pixel = 10'd391;
        cyc(1);
        chk("key_off", pixel_on, 1'b0);
        chk("key_color0", pixel_color, 10'd0);
        sprite_pixel = 10'd428;
        DrawX = X0 + 10'd2;
        DrawY = Y0;
        cyc(2);
        chk("tens_addr", {sprite_digit, sprite_row, sprite_col},
            {4'd4, 5'd0, 5'd2});
        chk("tens_on", pixel_on, 1'b1);
        DrawX = X0 + 10'd63;
        DrawY = Y0 + 10'd23;
        cyc(2);
        chk("corner_addr", {sprite_digit, sprite_row, sprite_col},
            {4'd7, 5'd23, 5'd31});
        chk("corner_on", pixel_on, 1'b1);
        DrawX = X0 + 10'd64;
        DrawY = Y0 + 10'd5;
        cyc(2);
        chk("right_edge_addr", {sprite_digit, sprite_row, sprite_col}, 14'd0);
        chk("right_edge_off", pixel_on, 1'b0);
        DrawX = X0 + 10'd33;
        DrawY = Y0 + 10'd24;
        cyc(2);
        chk("bottom_edge_off", pixel_on, 1'b0);
        DrawX = X0 - 10'd1;
        DrawY = Y0 + 10'd5;
        cyc(2);
        chk("left_edge_off", pixel_on, 1'b0);
        DrawX = X0 + 10'd33;
        DrawY = Y0 - 10'd1;
        cyc(2);
        chk("top_edge_off", pixel_on, 1'b0);
        DrawX = 10'd0;
        DrawY = 10'd0;

        tick(30);
        pulse_pause();
        tick(200);
        chk("paused_hold", {tens, ones}, 8'h47);
        pulse_pause();
        tick(29);
        chk("resume_hold", {tens, ones}, 8'h47);
        tick(1);
        chk("resume_46", {tens, ones}, 8'h46);
        tick(540);
        chk("run_37", {tens, ones}, 8'h37);
        pulse_pause();
        tick(60);
        chk("paused_37", {tens, ones}, 8'h37);
        start = 1'b1;
        pause = 1'b1;
        cyc(1);
        start = 1'b0;
        pause = 1'b0;
        chk("start_pause_90", {tens, ones}, 8'h90);
        tick(60);
        chk("start_wins_run", {tens, ones}, 8'h89);

        pulse_start();
        tick(5399);
        chk("full_01", {tens, ones}, 8'h01);
        chk("full_tu_low", time_up, 1'b0);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        chk("full_00", {tens, ones}, 8'h00);
        chk("full_tu_lag", time_up, 1'b0);
        cyc(1);
        chk("full_tu_high", time_up, 1'b1);
        tick(10);
        chk("full_hold_00", {tens, ones}, 8'h00);
        pulse_pause();
        cyc(2);
        chk("expired_pause_ign", time_up, 1'b1);

        pulse_start();
        tick(120);
        chk("pre_reset_88", {tens, ones}, 8'h88);
        DrawX = X0 + 10'd33;
        DrawY = Y0 + 10'd5;
        sprite_pixel = 10'd428;
        cyc(2);
        chk("pre_reset_on", pixel_on, 1'b1);
        Reset_n = 1'b0;
        cyc(1);
        Reset_n = 1'b1;
        chk("mid_rst_count", {tens, ones}, 8'h90);
        chk("mid_rst_on", pixel_on, 1'b0);
        chk("mid_rst_color", pixel_color, 10'd0);
        chk("mid_rst_addr", {sprite_digit, sprite_row, sprite_col}, 14'd0);
        chk("mid_rst_tu", time_up, 1'b0);
        DrawX = 10'd0;
        DrawY = 10'd0;
        tick(60);
        chk("mid_rst_idle", {tens, ones}, 8'h90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
